// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), derived totals,
// screen centre/extent values and a small window-decode helper.
package vga_timing_pkg;

  localparam int CNT_W          = 10;

  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;

  localparam int DEF_H_TOTAL    = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL    = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Screen extent and centre for pattern generators built on this timing.
  localparam int SCREEN_W       = DEF_H_ACTIVE;
  localparam int SCREEN_H       = DEF_V_ACTIVE;
  localparam int SCREEN_CX      = DEF_H_ACTIVE / 2;
  localparam int SCREEN_CY      = DEF_V_ACTIVE / 2;

  // True when lo <= pos < hi (half-open window on a counter value).
  function automatic logic in_window(
    input logic [CNT_W-1:0] pos,
    input logic [CNT_W-1:0] lo,
    input logic [CNT_W-1:0] hi
  );
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrap-at-total position counter for one screen axis. Reset parks the
// count at TOTAL-1 so the first enabled edge after reset lands on 0.
// o_carry is high on the cycle the count is about to wrap.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = 800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_carry
);

  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_at_last;

  assign w_at_last = (r_count == L_LAST);
  assign o_carry   = i_en & w_at_last;
  assign o_count   = r_count;

  // Count up while enabled, wrapping from TOTAL-1 to 0; reset parks at TOTAL-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= L_LAST;
    end else if (i_en) begin
      if (w_at_last) begin
        r_count <= {CNT_W{1'b0}};
      end else begin
        r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: horizontal/vertical position counters plus sync,
// active-video, line/frame strobes and a frame counter. All timing outputs
// are decodes of the registered counters, so they share the same (x, y)
// in every cycle and have no path from any input.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             active,
  output logic             hsync,
  output logic             vsync,
  output logic             next_frame,
  output logic             next_line,
  output logic [7:0]       frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] L_H_ACT      = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] L_HS_START   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] L_HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] L_V_ACT      = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] L_VS_START   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] L_VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] w_hpos;
  logic [CNT_W-1:0] w_vpos;
  logic             w_h_carry;
  logic             w_v_carry;
  logic             w_next_frame;
  logic [7:0]       r_frame_count;

  // Horizontal counter advances every pixel clock.
  vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (1'b1),
    .o_count (w_hpos),
    .o_carry (w_h_carry)
  );

  // Vertical counter advances only when the line wraps.
  vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_h_carry),
    .o_count (w_vpos),
    .o_carry (w_v_carry)
  );

  // Frame start of vertical blanking: first pixel of the first blank line.
  assign w_next_frame = (w_hpos == {CNT_W{1'b0}}) && (w_vpos == L_V_ACT);

  assign x           = w_hpos;
  assign y           = w_vpos;
  assign active      = (w_hpos < L_H_ACT) && (w_vpos < L_V_ACT);
  assign hsync       = ~in_window(w_hpos, L_HS_START, L_HS_END);
  assign vsync       = ~in_window(w_vpos, L_VS_START, L_VS_END);
  assign next_line   = (w_hpos == L_H_ACT);
  assign next_frame  = w_next_frame;
  assign frame_count = r_frame_count;

  // Count completed frames on each next_frame strobe, wrapping at 256.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_count <= 8'd0;
    end else if (w_next_frame) begin
      r_frame_count <= r_frame_count + 8'd1;
    end else begin
      r_frame_count <= r_frame_count;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen. One instance uses the full 640x480
// timing for reset, line and hsync checks; a second, tiny-timing instance
// (15 x 8 clocks per frame) makes whole-frame and 256-frame runs short.
// Small timing: H 8/2/3/2 (hsync low x=10..12), V 4/1/2/1 (vsync low y=5..6).
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       rst_f;
  logic       rst_s;

  logic [9:0] x_f, y_f, x_s, y_s;
  logic       act_f, hs_f, vs_f, nf_f, nl_f;
  logic       act_s, hs_s, vs_s, nf_s, nl_s;
  logic [7:0] fc_f, fc_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_sync_gen dut_full (
    .clk(clk), .rst(rst_f), .x(x_f), .y(y_f), .active(act_f),
    .hsync(hs_f), .vsync(vs_f), .next_frame(nf_f), .next_line(nl_f),
    .frame_count(fc_f)
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_small (
    .clk(clk), .rst(rst_s), .x(x_s), .y(y_s), .active(act_s),
    .hsync(hs_s), .vsync(vs_s), .next_frame(nf_s), .next_line(nl_s),
    .frame_count(fc_s)
  );

  task automatic test_reset();
    rst_f = 1'b1;
    rst_s = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({x_f, y_f, act_f, hs_f, vs_f, nl_f, nf_f, fc_f} !==
        {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_full: x=%0d y=%0d act=%b hs=%b vs=%b nl=%b nf=%b fc=%0d want 799 524 0 1 1 0 0 0",
               x_f, y_f, act_f, hs_f, vs_f, nl_f, nf_f, fc_f);
    end
    checks++;
    if ({x_s, y_s, act_s, fc_s} !== {10'd14, 10'd7, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_small: x=%0d y=%0d act=%b fc=%0d want 14 7 0 0", x_s, y_s, act_s, fc_s);
    end
    rst_f = 1'b0;
    rst_s = 1'b0;
    @(negedge clk);
    checks++;
    if ({x_f, y_f, act_f} !== {10'd0, 10'd0, 1'b1}) begin
      errors++;
      $display("FAIL release_full: x=%0d y=%0d act=%b want 0 0 1", x_f, y_f, act_f);
    end
    checks++;
    if ({x_s, y_s, act_s} !== {10'd0, 10'd0, 1'b1}) begin
      errors++;
      $display("FAIL release_small: x=%0d y=%0d act=%b want 0 0 1", x_s, y_s, act_s);
    end
  endtask

  // Full-timing line 0: starts sampled at (0,0).
  task automatic test_line();
    int act_cnt = 0;
    int nl_cnt  = 0;
    int nl_x    = -1;
    for (int c = 0; c < 800; c++) begin
      checks++;
      if (x_f !== 10'(c) || y_f !== 10'd0) begin
        errors++;
        $display("FAIL line_pos: x=%0d y=%0d want %0d 0", x_f, y_f, c);
      end
      checks++;
      if (act_f !== (c < 640) || nl_f !== (c == 640)) begin
        errors++;
        $display("FAIL line_decode: x=%0d act=%b nl=%b want %b %b", c, act_f, nl_f, c < 640, c == 640);
      end
      if (act_f === 1'b1) act_cnt++;
      if (nl_f === 1'b1) begin
        nl_cnt++;
        nl_x = int'(x_f);
      end
      @(negedge clk);
    end
    checks++;
    if (act_cnt != 640 || nl_cnt != 1 || nl_x != 640) begin
      errors++;
      $display("FAIL line_counts: active=%0d next_line=%0d at x=%0d want 640 1 640", act_cnt, nl_cnt, nl_x);
    end
    checks++;
    if (x_f !== 10'd0 || y_f !== 10'd1) begin
      errors++;
      $display("FAIL line_wrap: x=%0d y=%0d want 0 1", x_f, y_f);
    end
  endtask

  // Full-timing line 1: hsync low window, vsync stays high.
  task automatic test_hsync();
    int lo_cnt = 0;
    int first  = -1;
    int last   = -1;
    int vs_lo  = 0;
    for (int c = 0; c < 800; c++) begin
      if (hs_f === 1'b0) begin
        lo_cnt++;
        if (first < 0) first = int'(x_f);
        last = int'(x_f);
      end
      if (vs_f !== 1'b1) vs_lo++;
      @(negedge clk);
    end
    checks++;
    if (lo_cnt != 96 || first != 656 || last != 751) begin
      errors++;
      $display("FAIL hsync_window: low=%0d first=%0d last=%0d want 96 656 751", lo_cnt, first, last);
    end
    checks++;
    if (vs_lo != 0) begin
      errors++;
      $display("FAIL hsync_vsync_idle: vsync low %0d clocks want 0", vs_lo);
    end
  endtask

  // Small-timing full frame from (0,0): positions, vsync, next_frame.
  task automatic test_frame();
    int vs_lo  = 0;
    int nf_cnt = 0;
    int ex, ey;
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 120; c++) begin
      ex = c % 15;
      ey = c / 15;
      checks++;
      if (x_s !== 10'(ex) || y_s !== 10'(ey)) begin
        errors++;
        $display("FAIL frame_pos: x=%0d y=%0d want %0d %0d", x_s, y_s, ex, ey);
      end
      checks++;
      if (vs_s !== !(ey == 5 || ey == 6) || nf_s !== (ex == 0 && ey == 4) ||
          hs_s !== !(ex >= 10 && ex <= 12) || nl_s !== (ex == 8) ||
          act_s !== (ex < 8 && ey < 4)) begin
        errors++;
        $display("FAIL frame_decode: (%0d,%0d) vs=%b nf=%b hs=%b nl=%b act=%b", ex, ey, vs_s, nf_s, hs_s, nl_s, act_s);
      end
      if (vs_s === 1'b0) vs_lo++;
      if (nf_s === 1'b1) nf_cnt++;
      @(negedge clk);
    end
    checks++;
    if (vs_lo != 30 || nf_cnt != 1) begin
      errors++;
      $display("FAIL frame_counts: vsync_low=%0d next_frame=%0d want 30 1", vs_lo, nf_cnt);
    end
  endtask

  // Reset asserted for one clock mid-frame on both instances.
  task automatic test_mid_reset();
    bit found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (x_s === 10'd12 && y_s === 10'd3) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reset_small_reach: never reached (12,3), got 1 want 0 timeouts");
    end
    rst_s = 1'b1;
    @(negedge clk);
    checks++;
    if ({x_s, y_s, act_s, hs_s, vs_s, nl_s, nf_s, fc_s} !==
        {10'd14, 10'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL mid_reset_small: x=%0d y=%0d act=%b nl=%b nf=%b fc=%0d want 14 7 0 0 0 0",
               x_s, y_s, act_s, nl_s, nf_s, fc_s);
    end
    rst_s = 1'b0;
    @(negedge clk);
    checks++;
    if ({x_s, y_s, act_s, nl_s, nf_s} !== {10'd0, 10'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_release_small: x=%0d y=%0d act=%b nl=%b nf=%b want 0 0 1 0 0",
               x_s, y_s, act_s, nl_s, nf_s);
    end

    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      if (x_f === 10'd700 && y_f === 10'd2) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reset_full_reach: never reached (700,2), got 1 want 0 timeouts");
    end
    rst_f = 1'b1;
    @(negedge clk);
    checks++;
    if ({x_f, y_f, act_f, hs_f, vs_f, nl_f, nf_f, fc_f} !==
        {10'd799, 10'd524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL mid_reset_full: x=%0d y=%0d act=%b hs=%b vs=%b fc=%0d want 799 524 0 1 1 0",
               x_f, y_f, act_f, hs_f, vs_f, fc_f);
    end
    rst_f = 1'b0;
    @(negedge clk);
    checks++;
    if ({x_f, y_f, act_f, nl_f, nf_f} !== {10'd0, 10'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_release_full: x=%0d y=%0d act=%b nl=%b nf=%b want 0 0 1 0 0",
               x_f, y_f, act_f, nl_f, nf_f);
    end
  endtask

  // 256 small frames from (0,0): frame_count model, pulse spacing, wrap.
  task automatic test_frame_count();
    logic [7:0] exp_fc = 8'd0;
    int         pulses = 0;
    int         last_p = -1;
    bit         wrapped = 1'b0;
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 256 * 120; c++) begin
      checks++;
      if (fc_s !== exp_fc) begin
        errors++;
        $display("FAIL fc_value: cycle %0d fc=%0d want %0d", c, fc_s, exp_fc);
      end
      if (nf_s === 1'b1) begin
        pulses++;
        if (last_p >= 0) begin
          checks++;
          if (c - last_p != 120) begin
            errors++;
            $display("FAIL fc_spacing: %0d clocks between next_frame want 120", c - last_p);
          end
        end
        last_p = c;
        if (exp_fc == 8'd255) wrapped = 1'b1;
        exp_fc = exp_fc + 8'd1;
      end
      @(negedge clk);
    end
    checks++;
    if (pulses != 256 || !wrapped || fc_s !== 8'd0) begin
      errors++;
      $display("FAIL fc_wrap: pulses=%0d wrapped=%b fc=%0d want 256 1 0", pulses, wrapped, fc_s);
    end
  endtask

  initial begin
    rst_f = 1'b1;
    rst_s = 1'b1;
    @(negedge clk);
    test_reset();
    test_line();
    test_hsync();
    test_frame();
    test_mid_reset();
    test_frame_count();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
